// File: rtl/delay_sched.sv
// delay_sched: round-robin arbiter sharing one programmable delay counter
// among NREQ requesters. A grant latches the winner's delay (clamped to
// MAXD), counts 0..tgt while the request is held, then pulses done.
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 14,
    parameter int MAXD  = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt_o,
    output logic                  err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] MAXD_C = CBITS'(MAXD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    cur;
    logic [PW-1:0]    pick;
    logic             pick_vld;
    logic [CBITS-1:0] tgt;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] pick_dly;
    logic             pick_over;
    logic [CBITS-1:0] dly_a [NREQ];

    // Index that is k positions after p, wrapping modulo NREQ
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % NREQ);
    endfunction

    // Clamp a requested delay to the largest supported value
    function automatic logic [CBITS-1:0] clamp_dly(input logic [CBITS-1:0] d);
        return (d > MAXD_C) ? MAXD_C : d;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_dly
        assign dly_a[i] = dly[i*CBITS +: CBITS];
    end

    // Round-robin search starting just after the last granted index
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_vld && req[wrap_add(ptr, k)]) begin
                pick     = wrap_add(ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_dly  = dly_a[pick];
    assign pick_over = (pick_dly > MAXD_C);
    assign cnt_o     = cnt;

    // Delay target is pure data: latched at grant, no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE && pick_vld) begin
            tgt <= clamp_dly(pick_dly);
        end
    end

    // Arbitration / counting FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            cur   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cur   <= pick;
                        ptr   <= pick;
                        gnt   <= NREQ'(1) << pick;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                        if (pick_over) begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt > tgt) begin
                        err <= 1'b1;
                    end
                    if (!req[cur]) begin
                        // Abort: release without a completion pulse
                        gnt   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == tgt) begin
                        done  <= NREQ'(1) << cur;
                        gnt   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CBITS'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
// Scoreboard bench for delay_sched: stimulus pushes expected grant/done
// events, a negedge monitor pops and compares as the DUT produces them.
module tb_delay_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 14;
    localparam int MAXD  = 10000;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] dly;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [CBITS-1:0]      cnt_o;
    logic                  err;

    typedef struct {
        int kind;   // 0 = grant rises, 1 = done pulse
        int idx;
        int len;    // expected gnt length for done events
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAXD(MAXD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dly   (dly),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .cnt_o (cnt_o),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_g(input int idx);
        ev_t e;
        e.kind = 0; e.idx = idx; e.len = 0;
        q.push_back(e);
    endtask

    task automatic push_d(input int idx, input int len);
        ev_t e;
        e.kind = 1; e.idx = idx; e.len = len;
        q.push_back(e);
    endtask

    task automatic set_dly(input int idx, input int val);
        dly[idx*CBITS +: CBITS] = CBITS'(val);
    endtask

    // Wait (bounded) until n done pulses are observed; returns at a negedge
    task automatic wait_dones(input int n, input int budget, input string name);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (done != '0) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL %s: saw %0d done pulses, expected %0d", name, seen, n);
        end
    endtask

    // Monitor: grant rises and done pulses are matched against the queue
    initial begin
        logic [NREQ-1:0] prev_gnt;
        int run_len;
        ev_t e;
        prev_gnt = '0;
        run_len  = 0;
        forever begin
            @(negedge clk);
            checks++;
            if (busy !== (gnt != '0)) begin
                errors++;
                $display("FAIL busy_vs_gnt: busy=%0d gnt=%b", busy, gnt);
            end
            if (gnt != '0 && gnt != prev_gnt) begin
                run_len = 1;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: gnt=%b, expected no event", gnt);
                end else begin
                    e = q.pop_front();
                    if (e.kind != 0 || gnt !== (4'(1) << e.idx)) begin
                        errors++;
                        $display("FAIL grant_event: gnt=%b, expected grant to %0d (kind %0d)", gnt, e.idx, e.kind);
                    end
                end
            end else if (gnt != '0) begin
                run_len++;
            end
            if (done != '0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=%b, expected no event", done);
                end else begin
                    e = q.pop_front();
                    if (e.kind != 1 || done !== (4'(1) << e.idx) || run_len != e.len || prev_gnt !== done) begin
                        errors++;
                        $display("FAIL done_event: done=%b len=%0d, expected done to %0d len %0d (kind %0d)",
                                 done, run_len, e.idx, e.len, e.kind);
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        dly = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", cnt_o, 0);
        chk("reset_err", err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester, D = 5
        set_dly(0, 5);
        push_g(0);
        push_d(0, 6);
        req = 4'b0001;
        @(posedge clk);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_cnt_step", cnt_o, k);
            chk("t1_gnt", gnt, 4'b0001);
        end
        wait_dones(1, 5, "t1_done");
        req = '0;
        chk("t1_err", err, 0);

        // Reset so requester 0 wins first, then all four with D = 2
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_dly(i, 2);
        push_g(0); push_d(0, 3);
        push_g(1); push_d(1, 3);
        push_g(2); push_d(2, 3);
        push_g(3); push_d(3, 3);
        push_g(0); push_d(0, 3);
        req = 4'b1111;
        wait_dones(5, 40, "t2_dones");
        req = '0;
        chk("t2_err", err, 0);

        // Clamping: oversize delay on requester 1
        set_dly(1, 12000);
        push_g(1);
        push_d(1, MAXD + 1);
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        chk("t3_err_at_grant", err, 1);
        chk("t3_busy", busy, 1);
        wait_dones(1, MAXD + 10, "t3_done");
        req = '0;
        chk("t3_err_sticky", err, 1);

        // Abort requester 2 at cnt 3 with requester 3 pending
        set_dly(2, 10);
        set_dly(3, 1);
        push_g(2);
        push_g(3);
        push_d(3, 2);
        req = 4'b1100;
        @(posedge clk);
        repeat (4) @(negedge clk);
        chk("t4_cnt_before_abort", cnt_o, 3);
        req = 4'b1000;
        @(negedge clk);
        chk("t4_abort_gnt", gnt, 0);
        chk("t4_abort_cnt", cnt_o, 0);
        chk("t4_abort_done", done, 0);
        @(negedge clk);
        chk("t4_next_gnt", gnt, 4'b1000);
        wait_dones(1, 5, "t4_done3");
        req = '0;

        // Asynchronous reset mid-run at cnt 4
        set_dly(1, 10);
        push_g(1);
        req = 4'b0010;
        @(posedge clk);
        repeat (5) @(negedge clk);
        chk("t5_cnt_before_rst", cnt_o, 4);
        chk("t5_err_still_set", err, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cnt", cnt_o, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_err", err, 0);
        @(posedge clk);
        #1;
        set_dly(0, 1);
        set_dly(1, 3);
        push_g(0); push_d(0, 2);
        push_g(1); push_d(1, 4);
        req = 4'b0011;
        rst = 1'b0;
        wait_dones(2, 20, "t5_dones");
        req = '0;

        // D = 0 on requester 3
        set_dly(3, 0);
        push_g(3);
        push_d(3, 1);
        req = 4'b1000;
        wait_dones(1, 5, "t6_done");
        req = '0;
        chk("t6_err", err, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_sched.md
# delay_sched

Round-robin scheduler that shares one programmable delay counter among NREQ requesters. Each requester presents a delay length and holds a request. The block grants the counter to one requester at a time, counts out that delay, and returns a one-cycle completion pulse. It sits in front of the delay datapath so that several clients can time intervals without each instantiating its own CBITS-wide counter.

## Interface
- NREQ, 4: number of requesters; must be at least 2.
- CBITS, 14: counter width.
- MAXD, 10000: largest delay accepted; must be below 2^CBITS - 1.

- clk, in, 1: single clock; all logic is posedge.
- rst, in, 1: reset, asynchronous and active-high.
- req, in, NREQ: request level from each requester.
- dly, in, NREQ*CBITS: delay for requester i, taken from dly[i*CBITS +: CBITS]; sampled only at grant.
- gnt, out, NREQ: registered one-hot grant; all zeros when idle.
- done, out, NREQ: registered one-cycle completion pulse for the granted requester.
- busy, out, 1: high while in RUN.
- cnt_o, out, CBITS: current counter value; 0 when idle.
- err, out, 1: sticky error flag, cleared only by rst.

## Operation
- The FSM has two states, IDLE and RUN.
- Internal registers:
  - ptr: index of the last granted requester.
  - cur: index of the active requester.
  - tgt: latched delay target, CBITS wide.
  - cnt: counter, CBITS wide.
- IDLE, no req bit set: stay in IDLE; gnt = 0, busy = 0.
- IDLE, any req bit set:
  - Pick the first set bit scanning (ptr+1), (ptr+2), … mod NREQ.
  - Set cur to that index and ptr to that index.
  - Set gnt[cur] = 1 and cnt = 0.
  - Set tgt = min(dly_cur, MAXD).
  - Go to RUN.
- Grant-time error: if dly_cur > MAXD, set err at the same edge and still run with tgt = MAXD.
- RUN, req[cur] = 1 and cnt == tgt:
  - Set done[cur] = 1 for the next cycle.
  - Clear gnt and cnt to 0.
  - Go to IDLE.
- RUN, req[cur] = 1 and cnt != tgt: cnt = cnt + 1.
- RUN, req[cur] = 0 (abort):
  - Go to IDLE with gnt = 0 and cnt = 0.
  - No done pulse; ptr keeps the aborted index.
- Invariant: in RUN, cnt <= tgt <= MAXD. If cnt > tgt is ever reached, set err.
- Arithmetic: cnt + 1 is evaluated at CBITS width and never wraps, because tgt <= MAXD < 2^CBITS - 1.
- Fairness:
  - A requester that keeps req high after its done pulse has lowest priority at the next arbitration.
  - Worst-case wait is therefore (NREQ-1) × (MAXD + 2) cycles.
- Requests from requesters other than cur that arrive during RUN are ignored until IDLE.
- dly changes after the grant edge have no effect.

## Timing
- Reset values: state = IDLE, ptr = NREQ-1 (requester 0 wins first), gnt = 0, done = 0, busy = 0, cnt_o = 0, err = 0.
- Reset asserted mid-RUN clears all outputs asynchronously; no done pulse is produced.
- Grant latency: req sampled high in IDLE at edge e0 gives gnt and busy high after e0.
- Completion for delay D (0 <= D <= MAXD):
  - gnt stays high for exactly D+1 cycles.
  - done is high in the cycle after the last gnt cycle.
  - done and the next grant cannot overlap: done coincides with the IDLE cycle.
- Back-to-back service: the next grant can rise one cycle after the previous gnt falls, i.e. a one-cycle IDLE gap.
- D = 0: gnt is high for 1 cycle, then done pulses.
- Simultaneous requests in IDLE resolve in a single cycle by round-robin order.
- A done pulse is never asserted on two bits at once, and never twice for one grant.

## Test plan
- Single requester: rst, then req[0] = 1 with dly0 = 5.
  - gnt = 4'b0001 for 6 cycles, then done[0] for 1 cycle.
  - busy matches gnt; cnt_o steps 0..5; err = 0.
- All four requesters held high with dly = 2 each.
  - Grant order is 0, 1, 2, 3, 0.
  - Each gnt is 3 cycles with a 1-cycle gap; each done[i] fires once per grant.
- Clamping: dly1 = 12000 on the sole request.
  - err rises at the grant edge and stays high.
  - gnt is held for 10001 cycles; done[1] fires; err cleared only by rst.
- Abort: req[2] dropped at cnt = 3 with dly2 = 10.
  - Next cycle gnt = 0, cnt_o = 0, no done.
  - With req[3] pending, req[3] is granted the following cycle.
- Asynchronous reset mid-RUN: assert rst between edges at cnt = 4.
  - gnt, busy and cnt_o go to 0 immediately, with no done.
  - After release, requester 0 wins over requester 1 when both request.
- D = 0 on requester 3: gnt[3] for 1 cycle, then done[3]; no err.
